// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

  // Smallest usable clocks-per-bit; divisor values below this are clamped up.
  localparam int MIN_DIV = 2;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Write-side handshake bundle for the buffered UART transmitter.
// valid/ready: a word transfers on every rising clock where valid && ready; the master holds
// data stable while valid is high and not yet accepted; ready never depends on valid.
interface uart_tx_buffered_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered read/write pointers; the extra pointer bit separates full
// from empty. Read data is the current head, valid whenever empty is low.
module uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign level    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter with runtime baud divisor and back-to-back framing.
// Optional parity bit and parity_mode port are built when UART_TX_PARITY_EN is defined.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DIV_W-1:0]            divisor,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]                  parity_mode,
`endif
  uart_tx_buffered_if.slave           wr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        tx,
  output tx_state_t                   dbg_state
);
  localparam int BIT_W = $clog2(DATA_W) + 1;

  tx_state_t         state;
  tx_state_t         state_next;
  logic [DIV_W-1:0]  div_eff;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cnt;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] shift_q;
  logic [BIT_W-1:0]  bit_idx;
  logic              stop_idx;
  logic              full, empty, push, pop;
  logic              bit_done, stop_last, tx_d;
  logic              par_en_q, par_bit_q;

  assign wr.ready  = !full;
  assign push      = wr.valid && wr.ready;
  assign div_eff   = (divisor < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : divisor;
  assign bit_done  = (cnt == '0);
  assign stop_last = (STOP_BITS == 1) || stop_idx;
  // A new frame starts from IDLE, or directly out of the last stop clock for zero idle gap.
  assign pop       = !empty && ((state == IDLE) || ((state == STOP) && bit_done && stop_last));

  uart_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (wr.data),
    .pop       (pop),
    .pop_data  (head),
    .level     (fifo_level),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty) state_next = START;
      START:   if (bit_done) state_next = DATA;
      DATA:    if (bit_done && (bit_idx == BIT_W'(DATA_W - 1)))
                 state_next = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done) state_next = STOP;
      STOP:    if (bit_done && stop_last) state_next = empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
  end

  // Baud down-counter, shifter and bit/stop counters; divisor is latched only at frame start.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q    <= DIV_W'(MIN_DIV);
      cnt      <= '0;
      shift_q  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else if (pop) begin
      div_q    <= div_eff;
      cnt      <= div_eff - DIV_W'(1);
      shift_q  <= head;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else if (state != IDLE) begin
      if (!bit_done) begin
        cnt <= cnt - DIV_W'(1);
      end else begin
        cnt <= div_q - DIV_W'(1);
        if (state == DATA) begin
          shift_q <= shift_q >> 1;
          bit_idx <= bit_idx + BIT_W'(1);
        end
        if (state == STOP) stop_idx <= 1'b1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (pop) begin
      par_en_q  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
      par_bit_q <= (^head) ^ (parity_mode == PAR_ODD);
    end
  end
`else
  assign par_en_q  = 1'b0;
  assign par_bit_q = 1'b0;
`endif

  // tx is registered from the state decode, so the line trails the FSM by one clock.
  always_ff @(posedge clock) begin
    if (reset) tx <= 1'b1;
    else       tx <= tx_d;
  end

  assign busy      = (state != IDLE) || !empty;
  assign dbg_state = state;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: frame waveforms, FIFO flow control, divisor handling,
// reset abort; parity cases are built when UART_TX_PARITY_EN is defined.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] divisor;
  logic [4:0]  fifo_level;
  logic        busy;
  logic        tx;
  tx_state_t   dbg_state;
`ifdef UART_TX_PARITY_EN
  logic [1:0]  parity_mode;
`endif

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_buffered_if #(.DATA_W(8)) bus ();

  uart_tx_buffered #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16), .STOP_BITS(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .divisor     (divisor),
`ifdef UART_TX_PARITY_EN
    .parity_mode (parity_mode),
`endif
    .wr          (bus.slave),
    .fifo_level  (fifo_level),
    .busy        (busy),
    .tx          (tx),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
  endtask

  task automatic push_byte(input logic [7:0] d);
    int t;
    t = 0;
    @(negedge clock);
    bus.data  = d;
    bus.valid = 1'b1;
    while (!bus.ready && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (!bus.ready) check("push_timeout", 32'(bus.ready), 32'd1);
    exp_q.push_back(d);
    @(posedge clock);
    #1 bus.valid = 1'b0;
  endtask

  // Counts negedge samples until tx is seen low (inclusive).
  task automatic wait_start(output int wait_n);
    wait_n = 0;
    do begin
      @(negedge clock);
      wait_n++;
    end while (tx !== 1'b0 && wait_n < 2000);
  endtask

  // par: 0 none, 1 even, 2 odd. Checks every clock of the frame against the expected line level.
  task automatic check_frame(input string tag, input int div, input int par, output int wait_n);
    logic [7:0] d;
    logic       syms[$];
    int         errs;
    errs = 0;
    wait_start(wait_n);
    if (tx !== 1'b0) begin
      check({tag, "_start"}, 32'(tx), 32'd0);
      return;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_expq"}, 32'(exp_q.size()), 32'd1);
      return;
    end
    d = exp_q.pop_front();
    syms.push_back(1'b0);
    for (int i = 0; i < 8; i++) syms.push_back(d[i]);
    if (par == 1) syms.push_back(^d);
    else if (par == 2) syms.push_back(~^d);
    syms.push_back(1'b1);
    for (int k = 1; k < syms.size() * div; k++) begin
      @(negedge clock);
      if (tx !== syms[k / div]) errs++;
    end
    check(tag, 32'(errs), 32'd0);
  endtask

  initial begin
    int w, w2, t, lows;
    bit saw_full;
    reset     = 1'b1;
    bus.valid = 1'b0;
    bus.data  = '0;
    divisor   = 16'd4;
`ifdef UART_TX_PARITY_EN
    parity_mode = 2'b00;
`endif
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // 8N1 at div=4: 0x55, first low two edges after the push, 40 clocks total
    push_byte(8'h55);
    check_frame("f55_wave", 4, 0, w);
    check("f55_latency", 32'(w), 32'd3);
    @(negedge clock);
    check("f55_idle_tx", 32'(tx), 32'd1);
    check("f55_busy", 32'(busy), 32'd0);

    // divisor 0 and 1 clamp to 2 clocks per bit
    divisor = 16'd0;
    push_byte(8'hA5);
    check_frame("div0_wave", 2, 0, w);
    divisor = 16'd1;
    push_byte(8'h5A);
    check_frame("div1_wave", 2, 0, w);

    // divisor change mid-frame takes effect on the next frame only
    divisor = 16'd4;
    push_byte(8'h3C);
    push_byte(8'hC3);
    fork
      check_frame("div4_keep", 4, 0, w);
      begin
        repeat (12) @(negedge clock);
        divisor = 16'd8;
      end
    join
    check_frame("div8_next", 8, 0, w2);
    check("div8_gap", 32'(w2), 32'd1);

    // burst of 20 at div=3 with valid held
    divisor  = 16'd3;
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clock);
          bus.data  = 8'(i);
          bus.valid = 1'b1;
          t = 0;
          while (!bus.ready && t < 2000) begin
            if (fifo_level == 5'd16) saw_full = 1'b1;
            @(negedge clock);
            t++;
          end
          exp_q.push_back(8'(i));
          @(posedge clock);
        end
        #1 bus.valid = 1'b0;
      end
      begin
        for (int i = 0; i < 20; i++) begin
          check_frame("burst_wave", 3, 0, w);
          if (i > 0) check("burst_gap", 32'(w), 32'd1);
        end
      end
    join
    check("burst_ready_drop_at_16", 32'(saw_full), 32'd1);
    check("burst_all_sent", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    check("burst_idle_tx", 32'(tx), 32'd1);
    check("burst_busy_low", 32'(busy), 32'd0);
    check("burst_level", 32'(fifo_level), 32'd0);

    // full FIFO: write on the pop edge is refused, accepted the cycle after
    divisor = 16'd8;
    @(negedge clock);
    bus.valid = 1'b1;
    t = 0;
    while (fifo_level != 5'd16 && t < 200) begin
      bus.data = 8'(8'hA0 + t);
      @(negedge clock);
      t++;
    end
    check("full_level", 32'(fifo_level), 32'd16);
    check("full_ready", 32'(bus.ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    t = 0;
    while (fifo_level == 5'd16 && t < 300) begin
      @(negedge clock);
      t++;
    end
    check("full_pop_refused", 32'(fifo_level), 32'd15);
    @(negedge clock);
    check("full_accept_next", 32'(fifo_level), 32'd16);
    bus.valid = 1'b0;
    do_reset();
    check("flush_level", 32'(fifo_level), 32'd0);
    check("flush_ready", 32'(bus.ready), 32'd1);

    // reset during DATA bit 3 aborts the frame and flushes the queue
    divisor = 16'd4;
    push_byte(8'h00);
    push_byte(8'h00);
    wait_start(w);
    repeat (16) @(negedge clock);
    check("mid_bit3_low", 32'(tx), 32'd0);
    check("mid_state_data", 32'(dbg_state), 32'(DATA));
    reset = 1'b1;
    @(negedge clock);
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_level", 32'(fifo_level), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    lows = 0;
    repeat (100) begin
      @(negedge clock);
      if (tx !== 1'b1) lows++;
    end
    check("abort_no_frames", 32'(lows), 32'd0);

`ifdef UART_TX_PARITY_EN
    parity_mode = 2'b01;
    push_byte(8'h07);
    check_frame("par_even", 4, 1, w);
    parity_mode = 2'b10;
    push_byte(8'h07);
    check_frame("par_odd", 4, 2, w);
    parity_mode = 2'b11;
    push_byte(8'h07);
    check_frame("par_rsvd", 4, 0, w);
    @(negedge clock);
    check("par_rsvd_len", 32'(tx), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
